// File: rtl/ssm_pkg.sv
// Shared SSM datapath constants, FP16 element type and a width helper.
package ssm_pkg;

    localparam int unsigned DW           = 16;
    localparam int unsigned B_DEF        = 1;
    localparam int unsigned H_DEF        = 6;
    localparam int unsigned P_DEF        = 8;
    localparam int unsigned H_TOTAL      = 24;
    localparam int unsigned H_GROUPS_DEF = H_TOTAL / H_DEF;
    localparam int unsigned LANES_DEF    = 4;

    typedef logic [DW-1:0] fp16_t;

    // Bits needed to index n items, never less than one.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/pingpong_buf2.sv
// Two-entry wide register file; a write may reuse the slot being released this cycle.
module pingpong_buf2 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_done,
    output logic [W-1:0] rd_data,
    output logic [1:0]   count,
    output logic         accept_c
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    // Free if not full, or if the full buffer releases its head this cycle.
    always_comb begin
        accept_c = wr_en & ~clear & ((count < 2'd2) | rd_done);
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (accept_c) wr_ptr <= ~wr_ptr;
            if (rd_done)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, accept_c} - {1'b0, rd_done};
        end
    end

    // Payload storage; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (accept_c) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/y_stream_out.sv
// Buffers completed SSM head-group vectors and streams them out LANES elements per beat.
module y_stream_out
    import ssm_pkg::*;
#(
    parameter int unsigned B        = B_DEF,
    parameter int unsigned H        = H_DEF,
    parameter int unsigned P        = P_DEF,
    parameter int unsigned LANES    = LANES_DEF,
    parameter int unsigned H_GROUPS = H_GROUPS_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [B*H*P*DW-1:0]                  y_flat,
    input  logic                                 y_done,
    input  logic                                 clear,
    output logic                                 can_accept,
    output logic [LANES*DW-1:0]                  out_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 out_last,
    output logic [clog2_min1(H_GROUPS)-1:0]      out_group,
    output logic                                 ovf
);

    localparam int unsigned NE     = B * H * P;
    localparam int unsigned VEC_W  = NE * DW;
    localparam int unsigned BEAT_W = LANES * DW;
    localparam int unsigned BEATS  = NE / LANES;
    localparam int unsigned BW     = clog2_min1(BEATS);
    localparam int unsigned GW     = clog2_min1(H_GROUPS);

    logic [VEC_W-1:0] rd_data;
    logic [1:0]       count;
    logic             accept_c;
    logic [BW-1:0]    beat;
    logic [GW-1:0]    group;
    logic             hs;
    logic             last_beat;
    logic             final_hs;

    pingpong_buf2 #(.W(VEC_W)) u_buf (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .wr_en    (y_done),
        .wr_data  (y_flat),
        .rd_done  (final_hs),
        .rd_data  (rd_data),
        .count    (count),
        .accept_c (accept_c)
    );

    // Handshake decode and status outputs derived from registered state.
    always_comb begin
        out_valid  = (count != 2'd0);
        hs         = out_valid & out_ready;
        last_beat  = (beat == BW'(BEATS - 1));
        final_hs   = hs & last_beat;
        out_last   = out_valid & last_beat & (group == GW'(H_GROUPS - 1));
        out_group  = group;
        can_accept = (count < 2'd2);
    end

    // Select the current beat's lanes from the head buffer entry.
    always_comb begin
        out_data = '0;
        for (int unsigned i = 0; i < BEATS; i++) begin
            if (out_valid && (beat == BW'(i))) begin
                out_data = rd_data[i*BEAT_W +: BEAT_W];
            end
        end
    end

    // Beat/group counters and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat  <= '0;
            group <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            beat  <= '0;
            group <= '0;
            ovf   <= 1'b0;
        end else begin
            if (hs) beat <= last_beat ? '0 : beat + BW'(1);
            if (final_hs) begin
                group <= (group == GW'(H_GROUPS - 1)) ? '0 : group + GW'(1);
            end
            if (y_done && !accept_c) ovf <= 1'b1;
        end
    end

endmodule
